// File: rtl/pwm_capture.sv
//==============================================================================
// pwm_capture: measures high time and rise-to-rise period of a PWM input, with loss-of-signal flag.
// Option macro: PWM_CAPTURE_GLITCH_FILTER_EN (glitch filter after synchronizer). Rev 1.0
//==============================================================================
`default_nettype none

module pwm_capture #(
   parameter int CNT_W    = 20,
   parameter int TIMEOUT  = 1_000_000,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_width,
   output logic [CNT_W-1:0] period,
   output logic             meas_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             sync_a;
   logic             s;
   logic             s_d;
   logic             lvl;
   logic             rise;
   logic             fall;
   logic             tmo_hit;
   logic             do_latch;
   logic             do_update;
   logic             do_tmo;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] hi_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         s      <= 1'b0;
      end else begin
         sync_a <= pwm_in;
         s      <= sync_a;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int              FC_W    = $clog2(FILT_LEN + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

   logic            filt;
   logic [FC_W-1:0] filt_cnt;

   // Level follows s only after FILT_LEN consecutive samples disagreeing with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt     <= 1'b0;
         filt_cnt <= '0;
      end else if (s != filt) begin
         if (filt_cnt == FC_LAST) begin
            filt     <= s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FC_ONE;
         end
      end else begin
         filt_cnt <= '0;
      end
   end

   assign lvl = filt;
`else
   logic unused_filt_len;
   assign unused_filt_len = ^FILT_LEN;
   assign lvl             = s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d <= 1'b0;
      end else begin
         s_d <= lvl;
      end
   end

   assign rise    = lvl & ~s_d;
   assign fall    = ~lvl & s_d;
   assign tmo_hit = (per_cnt == TMO_VAL) && !rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Timeout wins over a coincident fall; a coincident rise closes the frame normally.
   always_comb begin
      state_nxt = state;
      do_latch  = 1'b0;
      do_update = 1'b0;
      do_tmo    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (tmo_hit) begin
               state_nxt = IDLE;
               do_tmo    = 1'b1;
            end else if (fall) begin
               state_nxt = LOW;
               do_latch  = 1'b1;
            end
         end
         LOW: begin
            if (rise) begin
               state_nxt = HIGH;
               do_update = 1'b1;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
               do_tmo    = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= CNT_ONE;
         hi_cnt  <= CNT_ONE;
      end else begin
         if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_ONE;
         end
         if ((state == HIGH) && (hi_cnt != CNT_MAX)) begin
            hi_cnt <= hi_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_hold    <= '0;
         high_width <= '0;
         period     <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (do_latch) begin
            hi_hold <= hi_cnt;
         end
         if (do_update) begin
            high_width <= hi_hold;
            period     <= per_cnt;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
         end else if (do_tmo) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
//==============================================================================
// tb_pwm_capture: directed bench for pwm_capture (TIMEOUT=5000). Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_capture;

   localparam int CNT_W = 20;
   localparam int TMO   = 5000;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_width;
   logic [CNT_W-1:0] period;
   logic             meas_valid;
   logic             timeout;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   int nq;

   int               ev_cyc[$];
   logic [CNT_W-1:0] ev_hw[$];
   logic [CNT_W-1:0] ev_per[$];

   pwm_capture #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TMO),
      .FILT_LEN(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_in    (pwm_in),
      .high_width(high_width),
      .period    (period),
      .meas_valid(meas_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (meas_valid) begin
         ev_cyc.push_back(cyc);
         ev_hw.push_back(high_width);
         ev_per.push_back(period);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int hi, input int per);
      drive(1'b1, hi);
      drive(1'b0, per - hi);
   endtask

   initial begin
      // Reset held with the input toggling
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         drive(i[0], 3);
      end
      check("rst_high_width", 32'(high_width), 0);
      check("rst_period", 32'(period), 0);
      check("rst_meas_valid", 32'(meas_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_no_strobe", ev_hw.size(), 0);
      rst_n = 1'b1;
      drive(1'b0, 20);

      // Steady frames then a duty change
      frame(150, 2000);
      frame(150, 2000);
      frame(150, 2000);
      frame(300, 2000);
      check("steady_count", ev_hw.size(), 3);
      check("steady_hw", 32'(ev_hw[0]), 150);
      check("steady_per", 32'(ev_per[0]), 2000);
      check("steady_gap1", ev_cyc[1] - ev_cyc[0], 2000);
      check("steady_gap2", ev_cyc[2] - ev_cyc[1], 2000);

      // Loss of signal: stuck high after a rise
      drive(1'b1, 10);
      check("duty_count", ev_hw.size(), 4);
      check("duty_hw", 32'(ev_hw[3]), 300);
      check("duty_per", 32'(ev_per[3]), 2000);
      drive(1'b1, 4985);
      check("tmo_not_yet", 32'(timeout), 0);
      drive(1'b1, 25);
      check("tmo_set", 32'(timeout), 1);
      check("tmo_hw_kept", 32'(high_width), 300);
      check("tmo_per_kept", 32'(period), 2000);
      check("tmo_no_strobe", ev_hw.size(), 4);

      // Resume: timeout clears only with the second rise
      drive(1'b0, 500);
      frame(250, 1500);
      check("resume_tmo_sticky", 32'(timeout), 1);
      check("resume_no_strobe", ev_hw.size(), 4);
      frame(150, 2000);
      check("resume_count", ev_hw.size(), 5);
      check("resume_hw", 32'(ev_hw[4]), 250);
      check("resume_per", 32'(ev_per[4]), 1500);
      check("resume_tmo_clr", 32'(timeout), 0);

      // Reset at cycle 800 of a frame
      drive(1'b1, 150);
      drive(1'b0, 650);
      rst_n = 1'b0;
      drive(1'b0, 5);
      check("midrst_hw", 32'(high_width), 0);
      check("midrst_per", 32'(period), 0);
      check("midrst_mv", 32'(meas_valid), 0);
      nq = ev_hw.size();
      rst_n = 1'b1;
      drive(1'b0, 1190);
      frame(150, 2000);
      check("midrst_first_rise", ev_hw.size(), nq);

      // Frame with a 2-cycle low glitch inside a 150-cycle high
      drive(1'b1, 60);
      drive(1'b0, 2);
      drive(1'b1, 88);
      drive(1'b0, 1850);
      drive(1'b1, 20);
      check("midrst_hw2", 32'(ev_hw[nq]), 150);
      check("midrst_per2", 32'(ev_per[nq]), 2000);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("glitch_count", ev_hw.size(), nq + 2);
      check("glitch_hw", 32'(ev_hw[nq + 1]), 150);
      check("glitch_per", 32'(ev_per[nq + 1]), 2000);
`else
      check("glitch_count", ev_hw.size(), nq + 3);
      check("glitch_hw_lt_150", 32'(ev_hw[ev_hw.size() - 1] < 150), 1);
      check("glitch_early_hw", 32'(ev_hw[nq + 1]), 60);
      check("glitch_early_per", 32'(ev_per[nq + 1]), 62);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
